// File: rtl/led_chaser.sv
// led_chaser: WIDTH-bit LED chase pattern with run/pause/idle button control.
// Define LED_CHASER_DEBOUNCE_EN to insert a DEB_CYCLES debouncer after each button synchroniser.
module led_chaser #(
  parameter int WIDTH      = 8,
  parameter int PERIOD     = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             step
);
  // state   | meaning
  // S_IDLE  | LEDs dark, waiting for a start edge
  // S_RUN   | step timer running, pattern advances at terminal count
  // S_PAUSE | pattern and step timer frozen
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_t;

  localparam int                CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(PERIOD - 1);
  localparam logic [WIDTH-1:0]  SEED     = WIDTH'(1);

  // bit 0 carries start, bit 1 carries stop
  logic [1:0] btn_meta, btn_sync, btn_lvl, btn_prev, btn_edge;
  logic       start_edge, stop_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_meta <= {stop, start};
      btn_sync <= btn_meta;
      btn_prev <= btn_lvl;
    end
  end

`ifdef LED_CHASER_DEBOUNCE_EN
  localparam int            DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [DW-1:0] deb_cnt [2];
  logic [1:0]    btn_filt;

  // Down-counter reloads whenever the input agrees with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_filt <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= DEB_LAST;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_filt[i]) begin
          deb_cnt[i] <= DEB_LAST;
        end else if (deb_cnt[i] == '0) begin
          btn_filt[i] <= btn_sync[i];
          deb_cnt[i]  <= DEB_LAST;
        end else begin
          deb_cnt[i] <= deb_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign btn_lvl = btn_filt;
`else
  assign btn_lvl = btn_sync;
`endif

  assign btn_edge   = btn_lvl & ~btn_prev;
  assign start_edge = btn_edge[0];
  assign stop_edge  = btn_edge[1];

  state_t           state_q, state_d;
  logic [CW-1:0]    remain_q, remain_d;
  logic [WIDTH-1:0] led_d, adv_led;
  logic             dir_q, dir_d, adv_dir;  // 0 moves toward the MSB
  logic [1:0]       mode_q, mode_d;
  logic             step_d;

  always_comb begin
    adv_led = led;
    adv_dir = dir_q;
    if (mode != mode_q) begin
      adv_led = SEED;
      adv_dir = 1'b0;
    end else begin
      case (mode_q)
        2'b00: adv_led = {led[WIDTH-2:0], led[WIDTH-1]};
        2'b01: adv_led = {led[0], led[WIDTH-1:1]};
        2'b10: begin
          if (!dir_q && led[WIDTH-1]) begin
            adv_dir = 1'b1;
            adv_led = {1'b0, led[WIDTH-1:1]};
          end else if (dir_q && led[0]) begin
            adv_dir = 1'b0;
            adv_led = {led[WIDTH-2:0], 1'b0};
          end else if (dir_q) begin
            adv_led = {1'b0, led[WIDTH-1:1]};
          end else begin
            adv_led = {led[WIDTH-2:0], 1'b0};
          end
        end
        default: adv_led = (&led) ? SEED : {led[WIDTH-2:0], 1'b1};
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    led_d    = led;
    remain_d = remain_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    step_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge && !stop_edge) begin
          state_d  = S_RUN;
          led_d    = SEED;
          remain_d = CNT_LAST;
          dir_d    = 1'b0;
          mode_d   = mode;
        end
      end
      S_RUN: begin
        // The cycle that sees the stop edge is still RUN time, so the timer ticks in it.
        if (remain_q == '0) begin
          remain_d = CNT_LAST;
          led_d    = adv_led;
          dir_d    = adv_dir;
          mode_d   = mode;
          step_d   = 1'b1;
        end else begin
          remain_d = remain_q - 1'b1;
        end
        if (stop_edge) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (stop_edge) begin
          state_d  = S_IDLE;
          led_d    = '0;
          remain_d = CNT_LAST;
        end else if (start_edge) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led      <= '0;
      remain_q <= CNT_LAST;
      dir_q    <= 1'b0;
      mode_q   <= 2'b00;
      step     <= 1'b0;
      running  <= 1'b0;
    end else begin
      led      <= led_d;
      remain_q <= remain_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      step     <= step_d;
      running  <= (state_d == S_RUN);
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser: directed scenarios plus randomized buttons/mode
// compared every cycle against a step-index reference model.
module tb_led_chaser;
  localparam int W   = 4;
  localparam int P   = 3;
  localparam int DEB = 4;
`ifdef LED_CHASER_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
  localparam int PW  = DEB + 2;
  localparam int PRE = DEB + 2;
`else
  localparam int LAT = 2;
  localparam int PW  = 1;
  localparam int PRE = 0;
`endif
  localparam int T_EFF = PRE + 1 + LAT;
  localparam int MM    = (T_EFF + 1) / 3;
  localparam int WW    = 3 * MM + 1 - T_EFF;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop  = 1'b0;
  logic [1:0]   mode  = 2'b00;
  logic [W-1:0] led;
  logic         running, step;
  logic [2:0]   led1;
  logic         running1, step1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_chaser #(.WIDTH(W), .PERIOD(P), .DEB_CYCLES(DEB)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .led(led), .running(running), .step(step)
  );

  led_chaser #(.WIDTH(3), .PERIOD(1), .DEB_CYCLES(DEB)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .led(led1), .running(running1), .step(step1)
  );

  // Reference model: pattern is a pure function of (mode_q, steps since seed).
  typedef enum int {M_IDLE, M_RUN, M_PAUSE} mst_t;
  mst_t        m_state = M_IDLE;
  int          m_idx   = 0;
  int          m_rt    = 0;
  logic [1:0]  m_mq    = 2'b00;
  bit          m_step  = 1'b0;
  logic [15:0] st_h = '0, sp_h = '0;
  logic [1:0]  st_f = '0, sp_f = '0;

  function automatic logic [W-1:0] pattern(input logic [1:0] md, input int idx);
    int k;
    int p;
    case (md)
      2'b00:   return W'(1) << (idx % W);
      2'b01:   return W'(1) << ((W - idx % W) % W);
      2'b10: begin
        p = idx % (2 * W - 2);
        return W'(1) << ((p < W) ? p : (2 * W - 2 - p));
      end
      default: begin
        k = idx % W;
        return W'((1 << (k + 1)) - 1);
      end
    endcase
  endfunction

  function automatic logic [W-1:0] m_led();
    return (m_state == M_IDLE) ? '0 : pattern(m_mq, m_idx);
  endfunction

  // h[i] is the button sampled i edges ago; returns {edge, new filtered history}.
  function automatic logic [2:0] btn_step(input logic [15:0] h, input logic [1:0] f);
    logic e;
    logic nf;
`ifdef LED_CHASER_DEBOUNCE_EN
    bit all_diff;
    e = f[0] & ~f[1];
    all_diff = 1'b1;
    for (int i = 2; i < DEB + 2; i++) if (h[i] == f[0]) all_diff = 1'b0;
    nf = all_diff ? ~f[0] : f[0];
`else
    e  = h[2] & ~h[3];
    nf = h[1];
`endif
    return {e, f[0], nf};
  endfunction

  always @(posedge clk or negedge rst_n) begin : ref_model
    logic [2:0] rs, rp;
    bit se, pe;
    if (!rst_n) begin
      m_state = M_IDLE; m_idx = 0; m_rt = 0; m_mq = 2'b00; m_step = 1'b0;
      st_h = '0; sp_h = '0; st_f = '0; sp_f = '0;
    end else begin
      st_h = {st_h[14:0], start};
      sp_h = {sp_h[14:0], stop};
      rs = btn_step(st_h, st_f); st_f = rs[1:0]; se = rs[2];
      rp = btn_step(sp_h, sp_f); sp_f = rp[1:0]; pe = rp[2];
      m_step = 1'b0;
      case (m_state)
        M_IDLE: if (se && !pe) begin
          m_state = M_RUN; m_idx = 0; m_rt = 0; m_mq = mode;
        end
        M_RUN: begin
          m_rt++;
          if (m_rt == P) begin
            m_rt = 0;
            m_step = 1'b1;
            if (mode != m_mq) begin m_mq = mode; m_idx = 0; end
            else m_idx++;
          end
          if (pe) m_state = M_PAUSE;
        end
        default: begin
          if (pe) begin m_state = M_IDLE; m_rt = 0; end
          else if (se) m_state = M_RUN;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check("model_led", 32'(led), 32'(m_led()));
    check("model_running", 32'(running), 32'(m_state == M_RUN));
    check("model_step", 32'(step), 32'(m_step));
  endtask

  task automatic press(input bit do_start, input bit do_stop);
    repeat (PRE) tick();
    if (do_start) start = 1'b1;
    if (do_stop)  stop  = 1'b1;
    repeat (PW) tick();
    start = 1'b0;
    stop  = 1'b0;
    repeat (LAT - PW + 1) tick();
  endtask

  logic [W-1:0] rl_exp  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [W-1:0] pp_exp  [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic [W-1:0] bar_exp [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b0001};
  logic [W-1:0] snap;

  initial begin
    repeat (3) tick();
    check("reset_led", 32'(led), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_step", 32'(step), 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Rotate left, plus PERIOD=1 instance advancing every cycle
    mode = 2'b00;
    press(1'b1, 1'b0);
    check("entry_led", 32'(led), 32'h1);
    check("entry_running", 32'(running), 32'h1);
    check("entry_step", 32'(step), 32'h0);
    check("p1_entry_led", 32'(led1), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rl_gap_step", 32'(step), 32'h0);
      if (i == 0) begin
        check("p1_led_a", 32'(led1), 32'h2);
        check("p1_step_a", 32'(step1), 32'h1);
      end
      tick();
      if (i == 0) begin
        check("p1_led_b", 32'(led1), 32'h4);
        check("p1_step_b", 32'(step1), 32'h1);
      end
      tick();
      check("rl_led", 32'(led), 32'(rl_exp[i]));
      check("rl_step", 32'(step), 32'h1);
    end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("idle_led", 32'(led), 32'h0);
    check("idle_p1_led", 32'(led1), 32'h0);

    // Ping-pong
    mode = 2'b10;
    press(1'b1, 1'b0);
    check("pp_entry_led", 32'(led), 32'h1);
    for (int i = 0; i < 7; i++) begin
      repeat (3) tick();
      check("pp_led", 32'(led), 32'(pp_exp[i]));
    end
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);

    // Bar fill, then switch to rotate right
    mode = 2'b11;
    press(1'b1, 1'b0);
    check("bar_entry_led", 32'(led), 32'h1);
    for (int i = 0; i < 4; i++) begin
      repeat (3) tick();
      check("bar_led", 32'(led), 32'(bar_exp[i]));
    end
    mode = 2'b01;
    repeat (3) tick();
    check("reseed_led", 32'(led), 32'h1);
    check("reseed_step", 32'(step), 32'h1);
    repeat (3) tick();
    check("rr_led", 32'(led), 32'h8);

    // Stop lands one cycle after an advance, hold, then resume
    repeat (WW) tick();
    press(1'b0, 1'b1);
    check("pause_running", 32'(running), 32'h0);
    snap = led;
    repeat (10) begin
      tick();
      check("pause_hold_led", 32'(led), 32'(snap));
      check("pause_running_hold", 32'(running), 32'h0);
    end
    press(1'b1, 1'b0);
    check("resume_running", 32'(running), 32'h1);
    check("resume_led", 32'(led), 32'(snap));
    tick();
    check("resume_step_early", 32'(step), 32'h0);
    tick();
    check("resume_step", 32'(step), 32'h1);
    check("resume_advanced", 32'(led != snap), 32'h1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("pause_clear_led", 32'(led), 32'h0);
    check("pause_clear_running", 32'(running), 32'h0);

    // Simultaneous start/stop in RUN, then asynchronous reset mid-pause
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check("both_running", 32'(running), 32'h0);
    check("both_led_lit", 32'(led != '0), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'h0);
    check("async_rst_running", 32'(running), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();

`ifdef LED_CHASER_DEBOUNCE_EN
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (12) tick();
    check("glitch_ignored", 32'(running), 32'h0);
`endif

    // Randomized buttons and mode against the model
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 11) == 0) start = ~start;
      if ($urandom_range(0, 15) == 0) stop  = ~stop;
      if ($urandom_range(0, 39) == 0) mode  = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
